ram16k_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 16K-word data RAM (16-bit data, 15-bit address, `ld` write strobe).
- Shares the single RAM port between the CPU data port (requester 0) and the loader/DMA port (requester 1).
- Uses a 3-state FSM with a req/ack handshake.
- Decodes the out-of-range address space (addr >= RAM_DEPTH) so that those accesses never reach the RAM.

---
 rtl/ram16k_arbiter.sv | 110 +++++++++++
 tb/tb_ram16k_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16k_arbiter.sv
// Two-requester arbiter and sequencer for the 16K-word data RAM.
// Each access runs IDLE -> ACC -> ACK, so one access completes every 3 cycles.
`timescale 1ns/1ps
module ram16k_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int RAM_DEPTH  = 16384,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_ld,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, ACK = 2'd2} state_t;

    // One extra bit so a RAM_DEPTH of 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(RAM_DEPTH);

    state_t            state, state_next;
    logic              last_grant, grant, lat_we, oor;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req, tie_win, win, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, rd_val;

    always_comb begin
        any_req   = req0 | req1;
        tie_win   = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        win       = (req0 & req1) ? tie_win : req1;
        sel_we    = win ? we1 : we0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        rd_val    = oor ? '0 : ram_out;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACC;
            ACC:     state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            oor        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= (state == ACC) & ~grant;
            ack1 <= (state == ACC) &  grant;
            err0 <= (state == ACC) & ~grant & oor;
            err1 <= (state == ACC) &  grant & oor;
            if (state == IDLE && any_req) begin
                grant      <= win;
                last_grant <= win;
                lat_we     <= sel_we;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                oor        <= ({1'b0, sel_addr} >= DEPTH);
            end
            // Read data lands on the ACC->ACK edge; writes leave rdata alone.
            if (state == ACC && !lat_we) begin
                if (grant) rdata1 <= rd_val;
                else       rdata0 <= rd_val;
            end
        end
    end

    // ram_ld is purely combinational so an asynchronous reset in ACC kills the write.
    assign ram_addr = lat_addr;
    assign ram_in   = lat_wdata;
    assign ram_ld   = (state == ACC) & lat_we & ~oor;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_ram16k_arbiter.sv
// Randomized bench for ram16k_arbiter with a transaction-level reference model
// and a behavioural RAM; directed scenarios pin the model with literal values.
`timescale 1ns/1ps
module tb_ram16k_arbiter;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 15;
    localparam int RAM_DEPTH = 16384;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, err0, ack1, err1, ram_ld, busy;
    logic [15:0] rdata0, rdata1, ram_in, ram_out;
    logic [14:0] ram_addr;

    logic        f_req0 = 0, f_req1 = 0, f_we = 0;
    logic [14:0] f_addr = '0;
    logic [15:0] f_wdata = '0, f_ram_out = 16'h1234;
    logic        f_ack0, f_err0, f_ack1, f_err1, f_ram_ld, f_busy;
    logic [15:0] f_rdata0, f_rdata1, f_ram_in;
    logic [14:0] f_ram_addr;

    ram16k_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .ram_addr(ram_addr), .ram_in(ram_in), .ram_ld(ram_ld), .ram_out(ram_out),
        .busy(busy)
    );

    ram16k_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(f_req0), .we0(f_we), .addr0(f_addr), .wdata0(f_wdata),
        .ack0(f_ack0), .rdata0(f_rdata0), .err0(f_err0),
        .req1(f_req1), .we1(f_we), .addr1(f_addr), .wdata1(f_wdata),
        .ack1(f_ack1), .rdata1(f_rdata1), .err1(f_err1),
        .ram_addr(f_ram_addr), .ram_in(f_ram_in), .ram_ld(f_ram_ld), .ram_out(f_ram_out),
        .busy(f_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [14:0] a);
        return {1'b0, a} ^ 16'hA5A5;
    endfunction

    // Behavioural RAM attached to the DUT
    logic [15:0] mem [0:32767];
    assign ram_out = mem[ram_addr];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = init_val(15'(i));
        forever begin
            @(posedge clk);
            if (ram_ld) mem[ram_addr] <= ram_in;
        end
    end

    // Reference model: each granted access occupies three cycles; its RAM effect
    // and read result appear at the end of the second cycle, ack in the third.
    int          m_phase;
    bit          m_last, m_g, m_we;
    logic [14:0] m_addr;
    logic [15:0] m_wd;
    logic        exp_ack0, exp_ack1, exp_err0, exp_err1;
    logic [15:0] exp_rdata0, exp_rdata1;
    logic [15:0] ref_mem [0:16383];
    bit          ref_wr  [0:16383];
    wire         win = (req0 && req1) ? !m_last : req1;

    function automatic bit in_range(input logic [14:0] a);
        return int'({17'b0, a}) < RAM_DEPTH;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [14:0] a);
        return ref_wr[a[13:0]] ? ref_mem[a[13:0]] : init_val(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_last <= 1'b1;
            exp_ack0 <= 0; exp_ack1 <= 0; exp_err0 <= 0; exp_err1 <= 0;
            exp_rdata0 <= '0; exp_rdata1 <= '0;
        end else begin
            exp_ack0 <= 0; exp_ack1 <= 0; exp_err0 <= 0; exp_err1 <= 0;
            if (m_phase == 0) begin
                if (req0 || req1) begin
                    m_phase <= 1;
                    m_g     <= win;
                    m_last  <= win;
                    m_we    <= win ? we1 : we0;
                    m_addr  <= win ? addr1 : addr0;
                    m_wd    <= win ? wdata1 : wdata0;
                end
            end else if (m_phase == 1) begin
                m_phase <= 2;
                if (m_g) begin exp_ack1 <= 1; exp_err1 <= !in_range(m_addr); end
                else     begin exp_ack0 <= 1; exp_err0 <= !in_range(m_addr); end
                if (m_we) begin
                    if (in_range(m_addr)) begin
                        ref_mem[m_addr[13:0]] <= m_wd;
                        ref_wr[m_addr[13:0]]  <= 1'b1;
                    end
                end else if (m_g) exp_rdata1 <= in_range(m_addr) ? ref_rd(m_addr) : 16'h0;
                else              exp_rdata0 <= in_range(m_addr) ? ref_rd(m_addr) : 16'h0;
            end else begin
                m_phase <= 0;
            end
        end
    end

    // Compare process plus ack log and ram_ld pulse count for directed checks
    int ack_id[$];
    int ack_cyc[$];
    int cyc = 0;
    int ld_cnt = 0;
    logic last_err1 = 0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("ack0",   32'(ack0),   32'(exp_ack0));
                chk("ack1",   32'(ack1),   32'(exp_ack1));
                chk("err0",   32'(err0),   32'(exp_err0));
                chk("err1",   32'(err1),   32'(exp_err1));
                chk("rdata0", 32'(rdata0), 32'(exp_rdata0));
                chk("rdata1", 32'(rdata1), 32'(exp_rdata1));
                chk("busy",   32'(busy),   32'(m_phase != 0));
                chk("ram_ld", 32'(ram_ld), 32'(m_phase == 1 && m_we && in_range(m_addr)));
                if (m_phase != 0) chk("ram_addr", 32'(ram_addr), 32'(m_addr));
                if (m_phase == 1 && m_we) chk("ram_in", 32'(ram_in), 32'(m_wd));
                if (ram_ld) ld_cnt++;
                if (ack0) begin ack_id.push_back(0); ack_cyc.push_back(cyc); end
                if (ack1) begin ack_id.push_back(1); ack_cyc.push_back(cyc); last_err1 = err1; end
            end
        end
    end

    // Requester driver: holds each transaction until its ack, then presents the next
    txn_t q0[$], q1[$];
    txn_t t0, t1;
    bit   act0 = 0, act1 = 0, drv_en = 0, rnd_en = 0, hold_rst = 0;

    task automatic gen_rand(output txn_t t);
        int r;
        r      = $urandom_range(0, 15);
        t.we   = 1'($urandom_range(0, 1));
        t.data = 16'($urandom);
        if (r == 0)      t.addr = 15'(32'h4000 + $urandom_range(0, 100));
        else if (r == 1) t.addr = 15'h7FFF;
        else             t.addr = 15'($urandom_range(0, 31));
    endtask

    initial begin
        t0 = '0; t1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n && !hold_rst) begin
                act0 = 0; act1 = 0;
            end else if (drv_en) begin
                if (act0 && ack0) act0 = 0;
                if (act1 && ack1) act1 = 0;
                if (!act0) begin
                    if (q0.size() > 0) begin t0 = q0.pop_front(); act0 = 1; end
                    else if (rnd_en && $urandom_range(0, 2) == 0) begin gen_rand(t0); act0 = 1; end
                end
                if (!act1) begin
                    if (q1.size() > 0) begin t1 = q1.pop_front(); act1 = 1; end
                    else if (rnd_en && $urandom_range(0, 2) == 0) begin gen_rand(t1); act1 = 1; end
                end
            end
            req0 = act0; we0 = t0.we; addr0 = t0.addr; wdata0 = t0.data;
            req1 = act1; we1 = t1.we; addr1 = t1.addr; wdata1 = t1.data;
        end
    end

    task automatic drain(input string nm);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || act0 || act1 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(nm, 32'(n >= 3000), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, c1, ld0;
        // Reset held with both requesters asking
        #2 rst_n = 1'b0;
        hold_rst = 1;
        q0.push_back('{we: 1'b0, addr: 15'h0005, data: 16'h0});
        q1.push_back('{we: 1'b0, addr: 15'h0006, data: 16'h0});
        drv_en = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack0",   32'(ack0),   32'd0);
            chk("rst_ack1",   32'(ack1),   32'd0);
            chk("rst_ram_ld", 32'(ram_ld), 32'd0);
            chk("rst_busy",   32'(busy),   32'd0);
            chk("rst_rdata",  32'({rdata0, rdata1}), 32'd0);
            chk("rst_addr",   32'(ram_addr), 32'd0);
        end
        chk("rst_req_held", 32'({req0, req1}), 32'd3);
        rst_n = 1'b1;
        hold_rst = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(ack0 || ack1) && n < 10);
        chk("first_ack_latency", 32'(n), 32'd2);
        chk("first_ack_is_0", 32'({ack0, ack1}), 32'b10);
        drain("drain_reset");
        chk("rdata0_after_rst_read", 32'(rdata0), 32'h0000A5A0);
        chk("rdata1_after_rst_read", 32'(rdata1), 32'h0000A5A3);

        // Single requester write then read
        ld0 = ld_cnt;
        q0.push_back('{we: 1'b1, addr: 15'h0123, data: 16'hBEEF});
        drain("drain_w0");
        chk("w0_ld_pulses", 32'(ld_cnt - ld0), 32'd1);
        chk("w0_mem", 32'(mem[15'h0123]), 32'h0000BEEF);
        q0.push_back('{we: 1'b0, addr: 15'h0123, data: 16'h0});
        drain("drain_r0");
        chk("r0_rdata0", 32'(rdata0), 32'h0000BEEF);
        chk("r0_rdata1_kept", 32'(rdata1), 32'h0000A5A3);

        // Out-of-range write and read by requester 1
        ld0 = ld_cnt;
        q1.push_back('{we: 1'b1, addr: 15'h4000, data: 16'h1111});
        drain("drain_oor_w");
        chk("oor_w_no_ld", 32'(ld_cnt - ld0), 32'd0);
        chk("oor_w_err1", 32'(last_err1), 32'd1);
        chk("oor_w_mem0", 32'(mem[0]), 32'h0000A5A5);
        q1.push_back('{we: 1'b0, addr: 15'h0123, data: 16'h0});
        drain("drain_r1");
        chk("r1_rdata1", 32'(rdata1), 32'h0000BEEF);
        chk("r1_err1", 32'(last_err1), 32'd0);
        q1.push_back('{we: 1'b0, addr: 15'h7FFF, data: 16'h0});
        drain("drain_oor_r");
        chk("oor_r_rdata1", 32'(rdata1), 32'd0);
        chk("oor_r_err1", 32'(last_err1), 32'd1);

        // Round-robin contention: 4 writes from each side
        ack_id.delete(); ack_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{we: 1'b1, addr: 15'(16'h0100 + k), data: 16'(16'h1000 + k)});
            q1.push_back('{we: 1'b1, addr: 15'(16'h0200 + k), data: 16'(16'h2000 + k)});
        end
        drain("drain_rr");
        chk("rr_ack_count", 32'(ack_id.size()), 32'd8);
        for (int k = 0; k < 8 && k < ack_id.size(); k++) begin
            chk("rr_order", 32'(ack_id[k]), 32'(k % 2));
            if (k > 0) chk("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
        end
        for (int k = 0; k < 4; k++) begin
            chk("rr_mem0", 32'(mem[16'h0100 + k]), 32'(16'h1000 + k));
            chk("rr_mem1", 32'(mem[16'h0200 + k]), 32'(16'h2000 + k));
        end

        // Randomized traffic, checked cycle by cycle against the model
        rnd_en = 1;
        repeat (900) @(negedge clk);
        rnd_en = 0;
        drain("drain_random");

        // Reset during the ACC cycle of a write
        q0.push_back('{we: 1'b1, addr: 15'h0010, data: 16'h0AAA});
        drain("drain_pre");
        q0.push_back('{we: 1'b1, addr: 15'h0010, data: 16'h5555});
        n = 0;
        do begin @(negedge clk); n++; end while (!ram_ld && n < 50);
        chk("mid_found_acc", 32'(ram_ld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ld_drop", 32'(ram_ld), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        ack_id.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_no_ack", 32'(ack_id.size()), 32'd0);
        chk("mid_mem_old", 32'(mem[15'h0010]), 32'h00000AAA);
        q0.push_back('{we: 1'b0, addr: 15'h0010, data: 16'h0});
        drain("drain_post");
        chk("mid_read_old", 32'(rdata0), 32'h00000AAA);

        // Fixed priority instance: requester 0 starves requester 1 while held
        f_req0 = 1; f_req1 = 1;
        c0 = 0; c1 = 0;
        repeat (12) begin
            @(negedge clk);
            if (f_ack0) c0++;
            if (f_ack1) c1++;
            chk("fp_no_ld", 32'(f_ram_ld), 32'd0);
            chk("fp_no_err", 32'({f_err0, f_err1}), 32'd0);
        end
        chk("fp_ack0_count", 32'(c0), 32'd4);
        chk("fp_ack1_count", 32'(c1), 32'd0);
        chk("fp_rdata0", 32'(f_rdata0), 32'h00001234);
        chk("fp_addr_in", 32'({f_ram_addr, f_ram_in}), 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!f_ack0 && n < 10);
        f_req0 = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!f_ack1 && n < 10);
        chk("fp_req1_latency", 32'(n), 32'd3);
        chk("fp_busy", 32'(f_busy), 32'd1);
        f_req1 = 0;
        @(negedge clk);
        chk("fp_rdata1", 32'(f_rdata1), 32'h00001234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
